// File: rtl/coordinate_streamer.sv
`default_nettype none
// ============================================================================
// Module   : coordinate_streamer
// Purpose  : Streams stored (X,Y) coordinate pairs from the coordinate memory
//            to the host one field at a time over a valid/ack handshake.
//            Optional XOR checksum output enabled by COORD_STREAM_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module coordinate_streamer #(
    parameter int COORD_W = 256,
    parameter int ADDR_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W:0]    numCoords,
    output logic               memRdEn,
    output logic [ADDR_W-1:0]  memAddr,
    input  logic [COORD_W-1:0] memXData,
    input  logic [COORD_W-1:0] memYData,
    output logic [COORD_W-1:0] coordOut,
    output logic               coordIsY,
    output logic               coordValid,
    input  logic               coordAck,
    output logic               busy,
    output logic               done
`ifdef COORD_STREAM_CHECKSUM_EN
    ,
    output logic [COORD_W-1:0] checksum
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SEND_X  = 3'd3;
    localparam logic [2:0] S_SEND_Y  = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;

    localparam logic [ADDR_W:0]   c_CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [ADDR_W:0]    r_count;
    logic [ADDR_W-1:0]  r_addr;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               w_start_ok;
    logic               w_last;
    logic               w_field_ack;

    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_FINISH));
    // The count is at least 1 whenever SEND_Y is reachable, so count-1 never underflows there.
    assign w_last      = ({1'b0, r_addr} == (r_count - c_CNT_ONE));
    assign w_field_ack = coordValid && coordAck;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_FINISH: begin
                if (start) begin
                    w_next = (numCoords != '0) ? S_FETCH : S_FINISH;
                end
            end
            S_FETCH:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_SEND_X;
            S_SEND_X: begin
                if (coordAck) begin
                    w_next = S_SEND_Y;
                end
            end
            S_SEND_Y: begin
                if (coordAck) begin
                    w_next = w_last ? S_FINISH : S_FETCH;
                end
            end
            default:   w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        memRdEn    = 1'b0;
        coordOut   = '0;
        coordIsY   = 1'b0;
        coordValid = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (r_state)
            S_IDLE:    busy = 1'b0;
            S_FETCH:   memRdEn = 1'b1;
            S_CAPTURE: ;
            S_SEND_X: begin
                coordValid = 1'b1;
                coordOut   = r_x;
            end
            S_SEND_Y: begin
                coordValid = 1'b1;
                coordIsY   = 1'b1;
                coordOut   = r_y;
            end
            S_FINISH: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default:   busy = 1'b0;
        endcase
    end

    // Count, address and holding registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_addr  <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            if (w_start_ok) begin
                r_count <= numCoords;
                r_addr  <= '0;
            end
            if (r_state == S_CAPTURE) begin
                r_x <= memXData;
                r_y <= memYData;
            end
            if ((r_state == S_SEND_Y) && coordAck && !w_last) begin
                r_addr <= r_addr + c_ADDR_ONE;
            end
        end
    end

    assign memAddr = r_addr;

`ifdef COORD_STREAM_CHECKSUM_EN
    logic [COORD_W-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_field_ack) begin
            r_checksum <= r_checksum ^ coordOut;
        end
    end

    assign checksum = r_checksum;
`else
    logic w_unused;
    assign w_unused = w_field_ack;
`endif

endmodule
`default_nettype wire

// File: doc/coordinate_streamer.md
# coordinate_streamer

Reads stored coordinate pairs back out of the coordinate memory and delivers them to the host one field at a time, X first and then Y. It uses the same per-field valid/acknowledge handshake that coordinate entry uses, so this block is the read-out end of that path. It sits between the coordinate memory's read port and the host interface. It runs after initialisation or after path computation, to export the stored or computed coordinates.

## Interface
- `COORD_W`, default 256: width of one X or Y coordinate word.
- `ADDR_W`, default 8: coordinate memory address width; depth is 2^ADDR_W pairs.
- `clk`, in, 1: sole clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request to stream; sampled only in IDLE and FINISH.
- `numCoords`, in, ADDR_W+1: number of pairs to stream; latched when `start` is accepted.
- `memRdEn`, out, 1: one-cycle memory read strobe.
- `memAddr`, out, ADDR_W: pair index being read.
- `memXData`, in, COORD_W: X word, valid the cycle after `memRdEn`.
- `memYData`, in, COORD_W: Y word, valid the cycle after `memRdEn`.
- `coordOut`, out, COORD_W: field presented to the host.
- `coordIsY`, out, 1: 0 when `coordOut` is X, 1 when it is Y.
- `coordValid`, out, 1: `coordOut` and `coordIsY` are valid.
- `coordAck`, in, 1: host accepts the current field.
- `busy`, out, 1: high in every state except IDLE and FINISH.
- `done`, out, 1: high while in FINISH.

## Operation
- States: IDLE, FETCH, CAPTURE, SEND_X, SEND_Y, FINISH.
- IDLE to FETCH: on `start` with `numCoords` != 0. Latch the count and set `memAddr` = 0.
- IDLE to FINISH: on `start` with `numCoords` == 0.
- FETCH: `memRdEn` = 1 for exactly one cycle, then go to CAPTURE.
- CAPTURE: register `memXData` and `memYData` into internal holding registers, then go to SEND_X.
- SEND_X:
  - `coordValid` = 1, `coordIsY` = 0, `coordOut` = held X.
  - Stays until `coordAck`, then goes to SEND_Y.
- SEND_Y:
  - `coordValid` = 1, `coordIsY` = 1, `coordOut` = held Y.
  - On `coordAck`: if `memAddr` == count-1, go to FINISH. Otherwise increment `memAddr` and go to FETCH.
- FINISH:
  - `done` = 1; the block holds here.
  - `start` re-enters the flow exactly as from IDLE and relatches `numCoords`.
- Boundaries:
  - `coordAck` while `coordValid` = 0 is ignored.
  - `start` while `busy` is ignored.
  - `numCoords` = 2^ADDR_W streams every address; `memAddr` never wraps past 2^ADDR_W-1.
  - `coordOut` is stable while `coordValid` is high and unacknowledged.
- The held X/Y registers make `memXData`/`memYData` don't-care outside the CAPTURE cycle.

## Timing
- Reset values: `memRdEn` = 0, `memAddr` = 0, `coordOut` = 0, `coordIsY` = 0, `coordValid` = 0, `busy` = 0, `done` = 0. State = IDLE.
- `reset` takes effect at the next edge from any state and aborts any partial pair.
- Start to first field: `start` sampled at edge T.
  - `memRdEn` is high in cycle T+1.
  - Capture happens at edge T+2.
  - `coordValid` goes high in cycle T+3.
- An acknowledged field completes at that edge.
  - X ack: Y is valid in the next cycle.
  - Y ack: the next X is valid 3 cycles later (FETCH, CAPTURE, SEND_X).
- Minimum per pair with `coordAck` tied high: 4 cycles.
- `done` rises the cycle after the final Y ack.
- `start` and `coordAck` are never combinationally coupled to outputs. All outputs are registered or decoded from state.

## Configuration
- Macro: `COORD_STREAM_CHECKSUM_EN`.
- Defined:
  - Adds output `checksum`, out, COORD_W.
  - It is cleared when `start` is accepted.
  - It XOR-accumulates `coordOut` on every acknowledged field.
  - It is stable and valid while `done` = 1, and reset value is 0.
- Undefined: the port and the accumulator are absent, and all other behaviour is identical.

## Test plan
- Reset, then `start` with `numCoords` = 1 and mem[0] = (X=5, Y=9), with `coordAck` held high:
  - `memRdEn` is high in T+1.
  - Fields are 5 then 9 with `coordIsY` = 0 then 1.
  - `done` is high at T+5.
- `numCoords` = 3 with mem = (1,2), (3,4), (5,6) and random ack delays of 0–5 cycles:
  - Output sequence is 1,2,3,4,5,6.
  - `coordOut` is stable while unacknowledged.
  - `memAddr` steps 0, 1, 2.
  - With the macro defined, `checksum` = 1^2^3^4^5^6 = 7.
- `numCoords` = 0: FINISH the cycle after `start`, no `memRdEn`, `coordValid` never asserted.
- Pulse `start` and `coordAck` during SEND_X before a real ack: extra `start` ignored, stray ack only advances to Y.
- `reset` asserted in SEND_Y of pair 1 of 3: all outputs return to reset values next cycle. A new `start` with `numCoords` = 2 restarts from address 0.
- `ADDR_W` = 2, `numCoords` = 4: addresses 0–3 streamed, then FINISH; no wrap to address 0.
